// File: rtl/ps2_pkg.sv
// ps2_pkg: shared scan-code constants, decoder state, event record and ASCII translation
package ps2_pkg;
  localparam logic [7:0] SC_E0  = 8'hE0;
  localparam logic [7:0] SC_F0  = 8'hF0;
  localparam logic [7:0] SC_E1  = 8'hE1;
  localparam logic [7:0] LSHIFT = 8'h12;
  localparam logic [7:0] RSHIFT = 8'h59;
  localparam logic [7:0] CAPS   = 8'h58;
  localparam logic [7:0] ENTER  = 8'h5A;
  localparam logic [7:0] SPACE  = 8'h29;
  localparam logic [7:0] BKSP   = 8'h66;
  localparam logic [7:0] TAB    = 8'h0D;
  localparam logic [7:0] ESC    = 8'h76;
  localparam logic [2:0] PAUSE_LEN = 3'd7;
  typedef enum logic [1:0] {IDLE, EXT, BRK, SKIP} state_t;
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic [7:0] ascii;
  } key_evt_t;
  function automatic logic [7:0] to_ascii(input logic [7:0] code, input logic ext,
                                          input logic rel, input logic shift, input logic caps);
    logic [7:0] l;
    l = 8'h00;
    case (code)
      8'h1C: l = "a"; 8'h32: l = "b"; 8'h21: l = "c"; 8'h23: l = "d";
      8'h24: l = "e"; 8'h2B: l = "f"; 8'h34: l = "g"; 8'h33: l = "h";
      8'h43: l = "i"; 8'h3B: l = "j"; 8'h42: l = "k"; 8'h4B: l = "l";
      8'h3A: l = "m"; 8'h31: l = "n"; 8'h44: l = "o"; 8'h4D: l = "p";
      8'h15: l = "q"; 8'h2D: l = "r"; 8'h1B: l = "s"; 8'h2C: l = "t";
      8'h3C: l = "u"; 8'h2A: l = "v"; 8'h1D: l = "w"; 8'h22: l = "x";
      8'h35: l = "y"; 8'h1A: l = "z";
      default: l = 8'h00;
    endcase
    if (rel) return 8'h00;
    if (ext) return (code == ENTER) ? 8'h0D : 8'h00;
    if (l != 8'h00) return (shift ^ caps) ? l - 8'h20 : l;
    case (code)
      8'h16: return shift ? "!" : "1";
      8'h1E: return shift ? "@" : "2";
      8'h26: return shift ? "#" : "3";
      8'h25: return shift ? "$" : "4";
      8'h2E: return shift ? "%" : "5";
      8'h36: return shift ? "^" : "6";
      8'h3D: return shift ? "&" : "7";
      8'h3E: return shift ? "*" : "8";
      8'h46: return shift ? "(" : "9";
      8'h45: return shift ? ")" : "0";
      SPACE: return 8'h20;
      ENTER: return 8'h0D;
      BKSP:  return 8'h08;
      TAB:   return 8'h09;
      ESC:   return 8'h1B;
      default: return 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: first-word fall-through FIFO of key events, wrap-bit pointers
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  key_evt_t din,
  output logic     full,
  input  logic     pop,
  output logic     empty,
  output key_evt_t dout
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [AW:0] wp, rp;
  key_evt_t mem [FIFO_DEPTH];
  logic wr, rd;
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign wr    = push & (~full | pop);
  assign rd    = pop & ~empty;
  assign dout  = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: strips Set 2 prefixes, tracks Shift/Caps, queues key events
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_release,
  output logic [7:0] evt_ascii,
  output logic       shift_held,
  output logic       caps_on,
  output logic       overflow
);
  state_t st, st_n;
  logic [2:0] cnt, cnt_n;
  logic ext_q, ext_n, sv_q, take_q, fire, f_ext, f_rel, mod;
  logic lsh, rsh, caps_held, full, empty, pop, ev_vq;
  logic [7:0] byte_q;
  key_evt_t ev_q, head;
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    ext_n = ext_q;
    fire  = 1'b0;
    f_ext = 1'b0;
    f_rel = 1'b0;
    if (take_q)
      case (st)
        IDLE: if (byte_q == SC_E0) st_n = EXT;
              else if (byte_q == SC_F0) begin st_n = BRK; ext_n = 1'b0; end
              else if (byte_q == SC_E1) begin st_n = SKIP; cnt_n = PAUSE_LEN; end
              else fire = !(byte_q inside {8'h00, 8'hAA, 8'hFA, 8'hFC, 8'hFE, 8'hFF});
        EXT:  if (byte_q == SC_F0) begin st_n = BRK; ext_n = 1'b1; end
              else begin fire = 1'b1; f_ext = 1'b1; st_n = IDLE; end
        BRK:  begin fire = 1'b1; f_ext = ext_q; f_rel = 1'b1; st_n = IDLE; end
        SKIP: begin cnt_n = cnt - 3'd1; st_n = (cnt == 3'd1) ? IDLE : SKIP; end
        default: st_n = IDLE;
      endcase
  end
  assign mod = fire & ~f_ext;
  always_ff @(posedge clk) begin
    if (rst) begin
      sv_q <= 1'b0; take_q <= 1'b0; byte_q <= '0;
      st <= IDLE; cnt <= '0; ext_q <= 1'b0;
      ev_q <= '0; ev_vq <= 1'b0;
      lsh <= 1'b0; rsh <= 1'b0; caps_on <= 1'b0; caps_held <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sv_q <= scan_valid;
      take_q <= scan_valid & ~sv_q;
      byte_q <= scan_code;
      st <= st_n; cnt <= cnt_n; ext_q <= ext_n;
      ev_vq <= fire;
      // ASCII is computed from the modifier state before this event updates it
      if (fire) ev_q <= '{byte_q, f_ext, f_rel, to_ascii(byte_q, f_ext, f_rel, shift_held, caps_on)};
      if (mod && byte_q == LSHIFT) lsh <= ~f_rel;
      if (mod && byte_q == RSHIFT) rsh <= ~f_rel;
      if (mod && byte_q == CAPS) begin
        caps_held <= ~f_rel;
        if (!f_rel && !caps_held) caps_on <= ~caps_on;
      end
      if (ev_vq && full && !pop) overflow <= 1'b1;
    end
  end
  assign shift_held  = lsh | rsh;
  assign evt_valid   = ~empty;
  assign pop         = evt_valid & evt_ready;
  assign evt_code    = head.code;
  assign evt_ext     = head.ext;
  assign evt_release = head.rel;
  assign evt_ascii   = head.ascii;
  ps2_evt_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (ev_vq),
    .din  (ev_q),
    .full (full),
    .pop  (pop),
    .empty(empty),
    .dout (head)
  );
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed scan-code sequences with hand-computed key events
module tb_ps2_scancode_decoder;
  logic clk = 1'b0, rst = 1'b1, scan_valid = 1'b0, evt_ready = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic evt_valid, evt_ext, evt_release, shift_held, caps_on, overflow;
  logic [7:0] evt_code, evt_ascii;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ps2_scancode_decoder #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .scan_code(scan_code), .scan_valid(scan_valid),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code), .evt_ext(evt_ext),
    .evt_release(evt_release), .evt_ascii(evt_ascii), .shift_held(shift_held),
    .caps_on(caps_on), .overflow(overflow)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] b);
    scan_code = b;
    scan_valid = 1'b1;
    tick(1);
    scan_valid = 1'b0;
    tick(1);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask
  task automatic pop_chk(input string tag, input logic [7:0] code, input logic ext,
                         input logic rel, input logic [7:0] ascii);
    int n = 0;
    while (!evt_valid && n < 10) begin
      tick(1);
      n++;
    end
    chk({tag, ".valid"}, evt_valid, 1);
    chk({tag, ".code"}, evt_code, code);
    chk({tag, ".ext"}, evt_ext, ext);
    chk({tag, ".rel"}, evt_release, rel);
    chk({tag, ".ascii"}, evt_ascii, ascii);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
  endtask
  logic [7:0] digit_code [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
  initial begin
    tick(1);
    do_reset();
    chk("rst.valid", evt_valid, 0);
    chk("rst.shift", shift_held, 0);
    chk("rst.caps", caps_on, 0);
    chk("rst.ovf", overflow, 0);
    chk("rst.code", evt_code, 0);
    chk("rst.ascii", evt_ascii, 0);
    // held scan_valid: one byte only, event visible after edge k+2
    scan_code = 8'h1C;
    scan_valid = 1'b1;
    tick(1);
    chk("lat.k", evt_valid, 0);
    tick(1);
    chk("lat.k1", evt_valid, 0);
    tick(1);
    chk("lat.k2", evt_valid, 1);
    scan_valid = 1'b0;
    tick(1);
    send(8'hF0); send(8'h1C);
    tick(3);
    pop_chk("t1.make", 8'h1C, 0, 0, 8'h61);
    pop_chk("t1.brk", 8'h1C, 0, 1, 8'h00);
    chk("t1.empty", evt_valid, 0);
    send(8'h12);
    chk("t2.sh_on", shift_held, 1);
    send(8'h1C); send(8'hF0); send(8'h12);
    chk("t2.sh_off", shift_held, 0);
    send(8'h16);
    tick(3);
    pop_chk("t2.shm", 8'h12, 0, 0, 8'h00);
    pop_chk("t2.A", 8'h1C, 0, 0, 8'h41);
    pop_chk("t2.shr", 8'h12, 0, 1, 8'h00);
    pop_chk("t2.one", 8'h16, 0, 0, 8'h31);
    send(8'h58);
    chk("t3.caps1", caps_on, 1);
    send(8'h58);
    chk("t3.rpt", caps_on, 1);
    send(8'hF0); send(8'h58);
    chk("t3.brk", caps_on, 1);
    send(8'h1C); send(8'h12); send(8'h1C); send(8'hF0); send(8'h12);
    tick(3);
    pop_chk("t3.c1", 8'h58, 0, 0, 8'h00);
    pop_chk("t3.c2", 8'h58, 0, 0, 8'h00);
    pop_chk("t3.cr", 8'h58, 0, 1, 8'h00);
    pop_chk("t3.A", 8'h1C, 0, 0, 8'h41);
    pop_chk("t3.sh", 8'h12, 0, 0, 8'h00);
    pop_chk("t3.a", 8'h1C, 0, 0, 8'h61);
    pop_chk("t3.shr", 8'h12, 0, 1, 8'h00);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h29);
    send(8'hE0); send(8'h5A);
    send(8'hFA);
    tick(3);
    pop_chk("t4.up", 8'h75, 1, 0, 8'h00);
    pop_chk("t4.upr", 8'h75, 1, 1, 8'h00);
    pop_chk("t4.sp", 8'h29, 0, 0, 8'h20);
    pop_chk("t4.kent", 8'h5A, 1, 0, 8'h0D);
    chk("t4.empty", evt_valid, 0);
    for (int i = 0; i < 9; i++) send(digit_code[i]);
    tick(3);
    chk("t5.ovf", overflow, 1);
    for (int i = 0; i < 8; i++) pop_chk($sformatf("t5.d%0d", i), digit_code[i], 0, 0, 8'h31 + 8'(i));
    chk("t5.empty", evt_valid, 0);
    do_reset();
    chk("t6.ovf_clr", overflow, 0);
    for (int i = 0; i < 8; i++) send(digit_code[i]);
    tick(3);
    chk("t6.ovf0", overflow, 0);
    scan_code = digit_code[8];
    scan_valid = 1'b1;
    tick(1);
    scan_valid = 1'b0;
    tick(1);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    tick(2);
    chk("t6.ovf", overflow, 0);
    for (int i = 0; i < 8; i++) pop_chk($sformatf("t6.d%0d", i), digit_code[i+1], 0, 0, 8'h32 + 8'(i));
    chk("t6.empty", evt_valid, 0);
    send(8'h12); send(8'h58);
    tick(3);
    send(8'hF0);
    rst = 1'b1;
    tick(1);
    chk("t7.valid", evt_valid, 0);
    chk("t7.shift", shift_held, 0);
    chk("t7.caps", caps_on, 0);
    chk("t7.code", evt_code, 0);
    chk("t7.ascii", evt_ascii, 0);
    rst = 1'b0;
    tick(1);
    send(8'h1C);
    tick(3);
    pop_chk("t7.make", 8'h1C, 0, 0, 8'h61);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
